// File: rtl/dbi_tx_pkg.sv
// Shared encodings for the DBI TX arbiter: FSM states, NOP byte, and grant helper.
// Pure definitions with no latency and no flow control.
package dbi_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_st_e;

    localparam logic [7:0] NOP_CMD = 8'h00;

    function automatic logic [1:0] st2gnt(input arb_st_e st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            GNT0:    g = 2'b01;
            GNT1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/dbi_tx_rr_arb2.sv
// Two-way round-robin pick, combinational grant from req and a registered favour bit.
// No backpressure; the favour bit moves only when advance is pulsed.
module dbi_tx_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // fav1 set means s1 wins a tie; the holder is the one still requesting at advance time
    logic fav1;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = fav1 ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fav1 <= 1'b0;
        end else if (advance) begin
            fav1 <= gnt[0];
        end
    end

endmodule

// File: rtl/dbi_tx_arb.sv
// Arbitrates two DBI beat streams onto the TX PHY; zero data latency, one bubble per transaction.
// PHY ready passes straight to the granted requester; a stalled owner is released after TMO_CYC idle cycles.
module dbi_tx_arb
    import dbi_tx_pkg::*;
#(
    parameter int DBI_IF_D_W = 8,
    parameter int TMO_CYC    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_hrst_i,
    input  logic [DBI_IF_D_W-1:0] s0_cmd_typ_i,
    input  logic [DBI_IF_D_W-1:0] s0_cmd_dat_i,
    input  logic                  s0_last_i,
    input  logic                  s0_no_dat_i,
    input  logic                  s0_vld_i,
    output logic                  s0_rdy_o,
    input  logic                  s1_hrst_i,
    input  logic [DBI_IF_D_W-1:0] s1_cmd_typ_i,
    input  logic [DBI_IF_D_W-1:0] s1_cmd_dat_i,
    input  logic                  s1_last_i,
    input  logic                  s1_no_dat_i,
    input  logic                  s1_vld_i,
    output logic                  s1_rdy_o,
    output logic                  dtp_dbi_hrst_o,
    output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o,
    output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o,
    output logic                  dtp_tx_last_o,
    output logic                  dtp_tx_no_dat_o,
    output logic                  dtp_tx_vld_o,
    input  logic                  dtp_tx_rdy_i,
    output logic [1:0]            arb_gnt_o,
    output logic                  arb_tmo_o
);

    localparam int            CW       = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    arb_st_e       st_q, st_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [1:0]    rr_req, rr_gnt;
    logic          txn_end, advance;

    // While granted, present the owner as the sole requester so advance records who held the bus
    assign rr_req  = (st_q == IDLE) ? {s1_vld_i, s0_vld_i} : st2gnt(st_q);
    assign advance = txn_end | arb_tmo_o;

    dbi_tx_rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rr_req),
        .advance (advance),
        .gnt     (rr_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            stall_q <= '0;
        end else begin
            st_q    <= st_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        st_d             = st_q;
        stall_d          = stall_q;
        dtp_dbi_hrst_o   = 1'b0;
        dtp_tx_cmd_typ_o = DBI_IF_D_W'(NOP_CMD);
        dtp_tx_cmd_dat_o = DBI_IF_D_W'(NOP_CMD);
        dtp_tx_last_o    = 1'b0;
        dtp_tx_no_dat_o  = 1'b0;
        dtp_tx_vld_o     = 1'b0;
        s0_rdy_o         = 1'b0;
        s1_rdy_o         = 1'b0;
        arb_tmo_o        = 1'b0;
        txn_end          = 1'b0;

        case (st_q)
            GNT0: begin
                dtp_dbi_hrst_o   = s0_hrst_i;
                dtp_tx_cmd_typ_o = s0_cmd_typ_i;
                dtp_tx_cmd_dat_o = s0_cmd_dat_i;
                dtp_tx_last_o    = s0_last_i;
                dtp_tx_no_dat_o  = s0_no_dat_i;
                dtp_tx_vld_o     = s0_vld_i;
                s0_rdy_o         = dtp_tx_rdy_i;
            end
            GNT1: begin
                dtp_dbi_hrst_o   = s1_hrst_i;
                dtp_tx_cmd_typ_o = s1_cmd_typ_i;
                dtp_tx_cmd_dat_o = s1_cmd_dat_i;
                dtp_tx_last_o    = s1_last_i;
                dtp_tx_no_dat_o  = s1_no_dat_i;
                dtp_tx_vld_o     = s1_vld_i;
                s1_rdy_o         = dtp_tx_rdy_i;
            end
            default: ;
        endcase

        txn_end   = dtp_tx_vld_o & dtp_tx_rdy_i & (dtp_tx_last_o | dtp_dbi_hrst_o);
        // Only an absent owner counts as a stall; PHY backpressure keeps vld high and clears the count
        arb_tmo_o = ((st_q == GNT0) || (st_q == GNT1)) & ~dtp_tx_vld_o
                    & (stall_q == TMO_LAST) & ~txn_end;

        case (st_q)
            IDLE: begin
                stall_d = '0;
                if (rr_gnt[0]) begin
                    st_d = GNT0;
                end else if (rr_gnt[1]) begin
                    st_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (txn_end || arb_tmo_o) begin
                    st_d    = IDLE;
                    stall_d = '0;
                end else if (dtp_tx_vld_o) begin
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
            end
            default: begin
                st_d    = IDLE;
                stall_d = '0;
            end
        endcase
    end

    assign arb_gnt_o = st2gnt(st_q);

endmodule
